act_stream_pipe: RTL

- Multi-channel, mode-selectable activation stage with valid/ready streaming and a 2-register pipeline.
- Sits between a conv/fc accumulator output and the next pooling or layer input.
- Applies one of pass, ReLU, leaky-ReLU or clamped-ReLU per beat to CH signed fixed-point lanes.
- Counts negative lanes for sparsity statistics.

---
 rtl/act_stream_pipe_pkg.sv | 14 +
 rtl/act_stream_pipe_lane.sv | 39 +++
 rtl/act_stream_pipe.sv | 131 +++++++++++++
 3 files changed

// File: rtl/act_stream_pipe_pkg.sv
// Shared definitions for the activation stream stage: default lane width and
// the activation mode encoding.
package act_stream_pipe_pkg;

    localparam int WD = 16;

    typedef enum logic [1:0] {
        ACT_PASS  = 2'b00,
        ACT_RELU  = 2'b01,
        ACT_LEAKY = 2'b10,
        ACT_CLAMP = 2'b11
    } act_mode_e;

endpackage

// File: rtl/act_stream_pipe_lane.sv
// One activation lane: purely combinational mode + x -> y on a signed
// DW-bit value. Every result fits in DW, so there is no width growth.
module act_lane
    import act_stream_pipe_pkg::*;
#(
    parameter int DW         = WD,
    parameter int LEAK_SHIFT = 3,
    parameter int CLAMP_VAL  = 16'h0600
) (
    input  act_mode_e     mode_i,
    input  logic [DW-1:0] x_i,
    output logic [DW-1:0] y_o
);

    localparam logic [DW-1:0] CLAMP_V = DW'(CLAMP_VAL);

    logic          neg;
    logic [DW-1:0] leak_v;

    assign neg    = x_i[DW-1];
    assign leak_v = $signed(x_i) >>> LEAK_SHIFT;

    always_comb begin
        // NOTE: default first so every path assigns y_o and no latch is inferred.
        y_o = x_i;
        case (mode_i)
            ACT_PASS:  y_o = x_i;
            ACT_RELU:  if (neg) y_o = '0;
            ACT_LEAKY: if (neg) y_o = leak_v;
            ACT_CLAMP: begin
                // x is non-negative here, so an unsigned compare is exact.
                if (neg)                y_o = '0;
                else if (x_i > CLAMP_V) y_o = CLAMP_V;
            end
            default:   y_o = x_i;
        endcase
    end

endmodule

// File: rtl/act_stream_pipe.sv
// Two-stage valid/ready activation pipeline over CH signed lanes, with a
// saturating counter of negative lanes on non-PASS beats.
module act_stream_pipe
    import act_stream_pipe_pkg::*;
#(
    parameter int DW         = WD,
    parameter int CH         = 6,
    parameter int LEAK_SHIFT = 3,
    parameter int CLAMP_VAL  = 16'h0600,
    parameter int CW         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode_i,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW*CH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW*CH-1:0] out_data,
    output logic             out_last,
    input  logic             cnt_clr,
    output logic [CW-1:0]    neg_cnt
);

    localparam int PCW = $clog2(CH + 1);

    logic             s1_v_q,    s1_v_d;
    logic [DW*CH-1:0] s1_data_q, s1_data_d;
    act_mode_e        s1_mode_q, s1_mode_d;
    logic             s1_last_q, s1_last_d;
    logic             s2_v_q,    s2_v_d;
    logic [DW*CH-1:0] s2_data_q, s2_data_d;
    logic             s2_last_q, s2_last_d;
    logic [CW-1:0]    neg_cnt_q, neg_cnt_d;

    logic             adv1, adv2, accept;
    logic [DW*CH-1:0] lane_y;
    logic [PCW-1:0]   neg_lanes;
    logic [CW:0]      cnt_sum;

    for (genvar g = 0; g < CH; g++) begin : g_lane
        act_lane #(
            .DW        (DW),
            .LEAK_SHIFT(LEAK_SHIFT),
            .CLAMP_VAL (CLAMP_VAL)
        ) u_lane (
            .mode_i(s1_mode_q),
            .x_i   (s1_data_q[g*DW +: DW]),
            .y_o   (lane_y[g*DW +: DW])
        );
    end

    // Stage 1 may refill in the same cycle stage 2 drains (bubble collapse).
    assign adv2      = !s2_v_q || out_ready;
    assign adv1      = !s1_v_q || adv2;
    assign in_ready  = adv1 && !rst;
    assign accept    = in_valid && in_ready;
    assign out_valid = s2_v_q;
    assign out_data  = s2_data_q;
    assign out_last  = s2_last_q;
    assign neg_cnt   = neg_cnt_q;

    always_comb begin
        s1_v_d    = s1_v_q;
        s1_data_d = s1_data_q;
        s1_mode_d = s1_mode_q;
        s1_last_d = s1_last_q;
        s2_v_d    = s2_v_q;
        s2_data_d = s2_data_q;
        s2_last_d = s2_last_q;

        if (adv1) begin
            s1_v_d = accept;
            if (accept) begin
                s1_data_d = in_data;
                s1_mode_d = act_mode_e'(mode_i);
                s1_last_d = in_last;
            end
        end

        if (adv2) begin
            s2_v_d = s1_v_q;
            if (s1_v_q) begin
                s2_data_d = lane_y;
                s2_last_d = s1_last_q;
            end
        end
    end

    always_comb begin
        neg_lanes = '0;
        for (int i = 0; i < CH; i++) begin
            neg_lanes = neg_lanes + PCW'(in_data[i*DW + DW-1]);
        end
        cnt_sum   = {1'b0, neg_cnt_q} + (CW+1)'(neg_lanes);

        neg_cnt_d = neg_cnt_q;
        if (cnt_clr) begin
            neg_cnt_d = '0;
        end else if (accept && act_mode_e'(mode_i) != ACT_PASS) begin
            neg_cnt_d = cnt_sum[CW] ? {CW{1'b1}} : cnt_sum[CW-1:0];
        end
    end

    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: data registers are reset too so out_data reads 0 after reset.
            s1_v_q    <= 1'b0;
            s1_data_q <= '0;
            s1_mode_q <= ACT_PASS;
            s1_last_q <= 1'b0;
            s2_v_q    <= 1'b0;
            s2_data_q <= '0;
            s2_last_q <= 1'b0;
            neg_cnt_q <= '0;
        end else begin
            s1_v_q    <= s1_v_d;
            s1_data_q <= s1_data_d;
            s1_mode_q <= s1_mode_d;
            s1_last_q <= s1_last_d;
            s2_v_q    <= s2_v_d;
            s2_data_q <= s2_data_d;
            s2_last_q <= s2_last_d;
            neg_cnt_q <= neg_cnt_d;
        end
    end

endmodule
